// File: rtl/croc_pkg.sv
// Shared SoC types: OBI manager-port request and response structures.
package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/obi_copy_pkg.sv
// Shared definitions for the OBI word-copy manager.
package obi_copy_pkg;

  localparam int unsigned DefaultLenW = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } copy_state_e;

endpackage

// File: rtl/obi_copy_mgr.sv
// OBI manager that copies len 32-bit words from src to dst, one transaction
// outstanding at a time, aborting on the first bus error.
module obi_copy_mgr
  import obi_copy_pkg::*;
#(
  parameter int unsigned LenW = DefaultLenW
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            src_addr_i,
  input  logic [31:0]            dst_addr_i,
  input  logic [LenW-1:0]        len_i,
  output croc_pkg::mgr_obi_req_t obi_req_o,
  input  croc_pkg::mgr_obi_rsp_t obi_rsp_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [LenW-1:0]        words_o
);

  copy_state_e     state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     data_q, data_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] words_q, words_d;
  logic            err_q, err_d;

  // One extra bit so the last-word compare cannot overflow at len = 2^LenW-1.
  logic [LenW:0]   words_inc;
  logic            last_word;

  logic            unused_inputs;
  assign unused_inputs = ^{src_addr_i[1:0], dst_addr_i[1:0],
                           obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

  assign words_inc = {1'b0, words_q} + {{LenW{1'b0}}, 1'b1};
  assign last_word = (words_inc == {1'b0, len_q});

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      len_q   <= len_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    len_d     = len_q;
    words_d   = words_q;
    err_d     = err_q;
    obi_req_o = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = {src_addr_i[31:2], 2'b00};
          dst_d   = {dst_addr_i[31:2], 2'b00};
          len_d   = len_i;
          words_d = '0;
          err_d   = 1'b0;
          state_d = (len_i != '0) ? RD_REQ : DONE;
        end
      end

      RD_REQ: begin
        obi_req_o.req    = 1'b1;
        obi_req_o.a.addr = src_q;
        obi_req_o.a.be   = 4'hF;
        if (obi_rsp_i.gnt) state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          data_d = obi_rsp_i.r.rdata;
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        obi_req_o.req     = 1'b1;
        obi_req_o.a.we    = 1'b1;
        obi_req_o.a.addr  = dst_q;
        obi_req_o.a.be    = 4'hF;
        obi_req_o.a.wdata = data_q;
        if (obi_rsp_i.gnt) state_d = WR_WAIT;
      end

      WR_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            words_d = words_inc[LenW-1:0];
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            state_d = last_word ? DONE : RD_REQ;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign words_o = words_q;

`ifndef SYNTHESIS
  // A request that is not granted must be held unchanged into the next cycle.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (obi_req_o.req && !obi_rsp_i.gnt) |=> (obi_req_o.req && $stable(obi_req_o.a)));

  assert property (@(posedge clk_i) (LenW >= 1) && (LenW <= 32));
`endif

endmodule

// File: tb/tb_obi_copy_mgr.sv
// Scoreboard bench for obi_copy_mgr: a bus slave model answers requests and
// a monitor checks every granted transaction against an expected queue.
module tb_obi_copy_mgr;
  import croc_pkg::*;

  localparam int unsigned LenW = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            start_i;
  logic [31:0]     src_addr_i;
  logic [31:0]     dst_addr_i;
  logic [LenW-1:0] len_i;
  mgr_obi_req_t    obi_req;
  mgr_obi_rsp_t    obi_rsp;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
  logic [LenW-1:0] words_o;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  txn_t exp_q[$];

  // Slave model controls
  int          gnt_delay = 0;
  int          err_read  = 0;
  int          rd_cnt    = 0;
  bit          stale_req = 1'b0;

  obi_copy_mgr #(.LenW(LenW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst,
                           input int full_words, input bit extra_read);
    txn_t t;
    for (int i = 0; i < full_words; i++) begin
      t.we = 1'b0; t.addr = src + 32'(4 * i); t.wdata = '0;
      exp_q.push_back(t);
      t.we = 1'b1; t.addr = dst + 32'(4 * i); t.wdata = rd_pat(src + 32'(4 * i));
      exp_q.push_back(t);
    end
    if (extra_read) begin
      t.we = 1'b0; t.addr = src + 32'(4 * full_words); t.wdata = '0;
      exp_q.push_back(t);
    end
  endtask

  // Bus slave: grant after gnt_delay stall cycles, respond one cycle after grant.
  initial begin
    int          stall;
    bit          pend, pend_we, gnt_now;
    logic [31:0] pend_addr;
    int          pend_idx;
    stall = 0; pend = 0; pend_we = 0; pend_addr = '0; pend_idx = 0;
    obi_rsp = '0;
    forever begin
      @(posedge clk_i); #1;
      obi_rsp.rvalid  = pend || stale_req;
      obi_rsp.r.rdata = (pend && !pend_we) ? rd_pat(pend_addr) : 32'h0;
      obi_rsp.r.err   = stale_req || (pend && !pend_we && pend_idx == err_read);
      stale_req = 1'b0;
      gnt_now = obi_req.req && (stall >= gnt_delay);
      obi_rsp.gnt = gnt_now;
      if (obi_req.req && !gnt_now) stall++;
      else stall = 0;
      pend = obi_req.req && gnt_now;
      if (pend) begin
        pend_we   = obi_req.a.we;
        pend_addr = obi_req.a.addr;
        if (!pend_we) begin
          rd_cnt++;
          pend_idx = rd_cnt;
        end
      end
    end
  end

  // Monitor: checks granted transactions, request stability and done pulses.
  initial begin
    bit           prev_stall;
    mgr_obi_a_chan_t prev_a;
    txn_t         t;
    prev_stall = 1'b0;
    prev_a = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_req_held", {31'd0, obi_req.req}, 32'd1);
          chk("stall_addr", obi_req.a.addr, prev_a.addr);
          chk("stall_we", {31'd0, obi_req.a.we}, {31'd0, prev_a.we});
          chk("stall_wdata", obi_req.a.wdata, prev_a.wdata);
        end
        if (obi_req.req) begin
          chk("req_be", {28'd0, obi_req.a.be}, 32'hF);
          chk("req_unused", {30'd0, obi_req.a.aid, obi_req.a.a_optional}, 32'd0);
          if (obi_rsp.gnt) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_req_addr", obi_req.a.addr, 32'hDEAD_BEEF);
            end else begin
              t = exp_q.pop_front();
              chk("txn_we", {31'd0, obi_req.a.we}, {31'd0, t.we});
              chk("txn_addr", obi_req.a.addr, t.addr);
              if (t.we) chk("txn_wdata", obi_req.a.wdata, t.wdata);
            end
          end
        end
        prev_stall = obi_req.req && !obi_rsp.gnt;
        prev_a     = obi_req.a;
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [LenW-1:0] len);
    @(posedge clk_i); #1;
    done_cnt   = 0;
    rd_cnt     = 0;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_words, input bit exp_err);
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk_i);
    chk({name, "_finished"}, {31'd0, done_cnt > 0}, 32'd1);
    repeat (3) @(negedge clk_i);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_words"}, 32'(words_o), 32'(exp_words));
    chk({name, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    chk({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit done_s[4];
    int busy_cycles;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
    done_s[0] = 0; busy_cycles = 0;
  end

  initial begin
    bit s_done[4];
    bit s_busy[4];
    int busy_cycles;

    rst_ni = 1'b0; start_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", {31'd0, obi_req.req}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_words", 32'(words_o), 32'd0);
    rst_ni = 1'b1;

    // Basic copy, immediate grant
    gnt_delay = 0; err_read = 0;
    push_copy(32'h1000, 32'h2000, 3, 0);
    start_copy(32'h1000, 32'h2000, 16'd3);
    wait_done("basic", 3, 0);

    // Grant stalls of 4 cycles, plus a start pulse while busy
    gnt_delay = 4;
    push_copy(32'h1000, 32'h2000, 3, 0);
    start_copy(32'h1000, 32'h2000, 16'd3);
    repeat (5) @(posedge clk_i);
    #1;
    src_addr_i = 32'h9000; dst_addr_i = 32'hA000; len_i = 16'd1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("stall", 3, 0);
    gnt_delay = 0;

    // Read error on the second read
    err_read = 2;
    push_copy(32'h4000, 32'h5000, 1, 1);
    start_copy(32'h4000, 32'h5000, 16'd4);
    wait_done("rderr", 1, 1);
    err_read = 0;

    // Zero length; start held through the DONE cycle must be ignored there
    @(posedge clk_i); #1;
    done_cnt = 0;
    src_addr_i = 32'h6000; dst_addr_i = 32'h7000; len_i = '0;
    start_i = 1'b1;
    @(negedge clk_i); s_done[0] = done_o; s_busy[0] = busy_o;
    @(posedge clk_i); #1;
    @(negedge clk_i); s_done[1] = done_o; s_busy[1] = busy_o;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i); s_done[2] = done_o; s_busy[2] = busy_o;
    @(negedge clk_i); s_done[3] = done_o; s_busy[3] = busy_o;
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) busy_cycles += int'(s_busy[i]);
    chk("zero_done_early", {31'd0, s_done[0]}, 32'd0);
    chk("zero_done_at_2", {31'd0, s_done[1]}, 32'd1);
    chk("zero_done_after", {31'd0, s_done[2] | s_done[3]}, 32'd0);
    chk("zero_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("zero_err_cleared", {31'd0, err_o}, 32'd0);
    chk("zero_words", 32'(words_o), 32'd0);

    // Reset while a write request is stalled
    push_copy(32'h8000, 32'h8800, 1, 1);
    start_copy(32'h8000, 32'h8800, 16'd3);
    for (int i = 0; i < 100 && words_o != 16'd1; i++) @(negedge clk_i);
    gnt_delay = 50;
    for (int i = 0; i < 100 && !(obi_req.req && obi_req.a.we); i++) @(negedge clk_i);
    chk("rst_mid_in_wr_req", {31'd0, obi_req.req && obi_req.a.we}, 32'd1);
    chk("rst_mid_words_before", 32'(words_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_req", {31'd0, obi_req.req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_words", 32'(words_o), 32'd0);
    rst_ni = 1'b1;
    gnt_delay = 0;
    stale_req = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("stale_busy", {31'd0, busy_o}, 32'd0);
    chk("stale_err", {31'd0, err_o}, 32'd0);
    chk("stale_words", 32'(words_o), 32'd0);
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    // Source address wrap; low destination bits are ignored
    push_copy(32'hFFFF_FFFC, 32'h3000, 2, 0);
    start_copy(32'hFFFF_FFFC, 32'h3002, 16'd2);
    wait_done("wrap", 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_copy_mgr.md
OBI_COPY_MGR -- requirements
Module: obi_copy_mgr

Interface
REQ-001 SHALL have parameter LenW, default 16, which is the bit width of the word-count port.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start_i, input, 1 bit: a single-cycle copy trigger.
REQ-005 SHALL have port src_addr_i, input, 32 bits: source byte address; bits [1:0] are ignored.
REQ-006 SHALL have port dst_addr_i, input, 32 bits: destination byte address; bits [1:0] are ignored.
REQ-007 SHALL have port len_i, input, LenW bits: number of 32-bit words to copy.
REQ-008 SHALL have port obi_req_o, output, croc_pkg::mgr_obi_req_t: the OBI manager request.
REQ-009 SHALL have port obi_rsp_i, input, croc_pkg::mgr_obi_rsp_t: the OBI manager response.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a copy is in progress.
REQ-011 SHALL have port done_o, output, 1 bit: a one-cycle pulse at the end of a copy, whether it succeeded or aborted.
REQ-012 SHALL have port err_o, output, 1 bit: sticky flag set when the last copy aborted on a bus error.
REQ-013 SHALL have port words_o, output, LenW bits: number of words written so far in the current or last copy.

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-015 IDLE + start_i SHALL do the following:
- latch src/dst with bits [1:0] forced to 0, and latch len;
- clear err_o and words_o;
- go to RD_REQ if len != 0, else go to DONE.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 RD_REQ SHALL drive req=1, we=0, be=4'hF, addr=cur_src, aid=0, and hold all of them stable until gnt; gnt moves the FSM to RD_WAIT.
REQ-018 RD_WAIT SHALL drive req=0, accept rvalid no earlier than the cycle after gnt, and capture r.rdata into a data register.
- If r.err=0, go to WR_REQ.
- If r.err=1, set err_o and go to DONE.
REQ-019 WR_REQ SHALL drive req=1, we=1, be=4'hF, addr=cur_dst, wdata=captured data, held stable until gnt; gnt moves the FSM to WR_WAIT.
REQ-020 WR_WAIT on rvalid SHALL behave as follows:
- If r.err=1, set err_o and go to DONE; words_o is not incremented.
- Otherwise increment words_o and add 4 to both cur_src and cur_dst, with 32-bit wrap-around.
- Then go to DONE if words_o+1 == len, else go to RD_REQ.
REQ-021 At most one transaction SHALL be outstanding, and req SHALL never be asserted in *_WAIT, IDLE or DONE.
REQ-022 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
- A start_i arriving in that cycle is ignored.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 rvalid SHALL be ignored in IDLE, RD_REQ, WR_REQ and DONE, so a stale response arriving after reset does no harm.
REQ-025 len = 2^LenW-1 SHALL complete without counter overflow.
REQ-026 All unused request fields (a.aid, a.a_optional) SHALL be driven to 0.

Reset
REQ-027 While rst_ni=0 at a clock edge, the FSM SHALL go to IDLE and obi_req_o.req, busy_o, done_o, err_o and words_o SHALL all become 0.
REQ-028 A reset asserted mid-copy SHALL abort the copy at that edge with no done_o pulse.
- A req that was pending without gnt is dropped; this is permitted only under reset.
REQ-029 Internal address, length and data registers SHALL reset to 0.

Structure
REQ-030 The FSM state enum typedef and the default LenW constant SHALL live in the package obi_copy_pkg.
REQ-031 OBI request and response types SHALL come from croc_pkg, with no local redefinition.
REQ-032 The block SHALL be a single module with no sub-module; the address/length datapath is small enough to stay inline.
REQ-033 A simulation-only assertion SHALL check that req and its address are stable while gnt=0, and that LenW is in the range [1,32].

Verification
REQ-034 The bench SHALL cover a basic copy:
- stimulus: src=0x1000, dst=0x2000, len=3, gnt in the same cycle as req, rvalid one cycle later;
- response: reads at 0x1000/1004/1008 and writes at 0x2000/2004/2008 with the read data, words_o=3, one done_o pulse, err_o=0.
REQ-035 The bench SHALL cover gnt stalls:
- stimulus: gnt delayed 4 cycles on every request;
- response: addr, we and wdata stay stable during each stall, and the copy result matches REQ-034.
REQ-036 The bench SHALL cover a read error:
- stimulus: len=4, r.err=1 on the 2nd read;
- response: no further requests, err_o=1, words_o=1, done_o pulses once.
REQ-037 The bench SHALL cover zero length:
- stimulus: len=0;
- response: no req asserted, done_o pulses 2 cycles after start_i, busy_o is high for 1 cycle.
REQ-038 The bench SHALL cover reset mid-copy and start while busy:
- stimulus: reset during WR_REQ;
- response: req=0 and busy_o=0 after the edge, no done_o, and a stale rvalid afterwards is ignored;
- stimulus: start_i while busy;
- response: start_i is ignored.
REQ-039 The bench SHALL cover address wrap:
- stimulus: src=0xFFFF_FFFC, len=2;
- response: the second read address is 0x0000_0000.
